// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multi-bank SRAM array controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAKE,
    ACCESS
  } ctrl_state_t;

  // Number of address bits needed to select one of 'banks' banks.
  function automatic int unsigned bank_w(input int unsigned banks);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < banks) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bank_power_ctrl.sv
// Per-bank power gate: idle counter with saturating timeout and a sleep flag.
module bank_power_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wake,
  input  logic busy,
  output logic sleep
);

  localparam int unsigned CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sleep_q, sleep_d;

  always_comb begin
    cnt_d   = cnt_q;
    sleep_d = sleep_q;
    // Being targeted wins over a timeout expiring in the same cycle.
    if (wake || busy) begin
      cnt_d   = '0;
      sleep_d = 1'b0;
    end else if (!sleep_q && (IDLE_TIMEOUT != 0) && (cnt_q != CNT_W'(IDLE_TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) sleep_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sleep_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      sleep_q <= sleep_d;
    end
  end

  assign sleep = sleep_q;

endmodule

// File: rtl/mem_array_ctrl.sv
// Multi-bank SRAM array controller: single-request handshake, bank routing and per-bank power gating.
module mem_array_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BANKS        = 2,
  parameter int unsigned WAKE_CYCLES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_r,
  input  logic                                req_w,
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [DATA_W-1:0]                   wdata,
  output logic                                ready,
  output logic                                done,
  output logic [DATA_W-1:0]                   rdata,
  output logic                                rdata_valid,
  output logic                                err,
  output logic [BANKS-1:0]                    bank_sleep,
  output logic                                arr_en,
  output logic                                arr_rw,
  output logic [bank_w(BANKS)-1:0]            arr_bank,
  output logic [ADDR_W-bank_w(BANKS)-1:0]     arr_addr,
  output logic [DATA_W-1:0]                   arr_wdata,
  input  logic [DATA_W-1:0]                   arr_rdata
);

  localparam int unsigned BANK_W = bank_w(BANKS);
  localparam int unsigned WORD_W = ADDR_W - BANK_W;
  localparam int unsigned WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  ctrl_state_t       state_q, state_d;
  logic              rw_q, rw_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [WORD_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WCNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic [BANKS-1:0]  wake_vec, busy_vec;
  logic [BANK_W-1:0] req_bank;

  assign req_bank = addr[ADDR_W-1 -: BANK_W];

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    bank_d     = bank_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wake_cnt_d = wake_cnt_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    wake_vec   = '0;
    busy_vec   = '0;
    unique case (state_q)
      IDLE: begin
        if (req_r ^ req_w) begin
          rw_d               = req_w;
          bank_d             = req_bank;
          waddr_d            = addr[WORD_W-1:0];
          wdata_d            = wdata;
          wake_vec[req_bank] = 1'b1;
          if (bank_sleep[req_bank]) begin
            state_d    = WAKE;
            wake_cnt_d = WCNT_W'(WAKE_CYCLES - 1);
          end else begin
            state_d = ACCESS;
          end
        end else if (req_r && req_w) begin
          err_d = 1'b1;
        end
      end
      WAKE: begin
        busy_vec[bank_q] = 1'b1;
        if (wake_cnt_q == '0) state_d = ACCESS;
        else                  wake_cnt_d = wake_cnt_q - WCNT_W'(1);
      end
      ACCESS: begin
        busy_vec[bank_q] = 1'b1;
        done_d           = 1'b1;
        state_d          = IDLE;
        if (!rw_q) begin
          rdata_d  = arr_rdata;
          rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      bank_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wake_cnt_q <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      bank_q     <= bank_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wake_cnt_q <= wake_cnt_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    bank_power_ctrl #(
      .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_bank (
      .clk  (clk),
      .rst_n(rst_n),
      .wake (wake_vec[g]),
      .busy (busy_vec[g]),
      .sleep(bank_sleep[g])
    );
  end

  assign ready       = (state_q == IDLE);
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign err         = err_q;
  assign arr_en      = (state_q == ACCESS);
  assign arr_rw      = arr_en & rw_q;
  assign arr_bank    = arr_en ? bank_q  : '0;
  assign arr_addr    = arr_en ? waddr_q : '0;
  assign arr_wdata   = arr_en ? wdata_q : '0;

endmodule

// File: tb/tb_mem_array_ctrl.sv
// Directed bench for mem_array_ctrl at default parameters, with a behavioural SRAM model.
module tb_mem_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_r, req_w;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       ready, done, rdata_valid, err;
  logic [7:0] rdata;
  logic [1:0] bank_sleep;
  logic       arr_en, arr_rw;
  logic [0:0] arr_bank;
  logic [2:0] arr_addr;
  logic [7:0] arr_wdata, arr_rdata;

  logic [7:0] mem [16];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         en_cnt  = 0;
  int         en_base;

  always #5 clk = ~clk;

  mem_array_ctrl #(
    .ADDR_W(4), .DATA_W(8), .BANKS(2), .WAKE_CYCLES(2), .IDLE_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_r(req_r), .req_w(req_w), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
    .bank_sleep(bank_sleep), .arr_en(arr_en), .arr_rw(arr_rw), .arr_bank(arr_bank),
    .arr_addr(arr_addr), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata)
  );

  assign arr_rdata = mem[{arr_bank, arr_addr}];

  always @(posedge clk) if (arr_en && arr_rw) mem[{arr_bank, arr_addr}] <= arr_wdata;

  always @(negedge clk) if (arr_en) en_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0; req_r = 1'b0; req_w = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sleep", bank_sleep, 2'b11);
    check("rst_ready", ready, 1);
    check("rst_outs", {done, rdata_valid, err, arr_en, rdata}, 0);
    rst_n = 1'b1;
    tick();

    // cycle 0: cold write 0xA5 to bank 0
    check("c0_ready", ready, 1);
    req_w = 1'b1; addr = 4'h3; wdata = 8'hA5;
    tick();
    req_w = 1'b0;
    check("c1_sleep", bank_sleep, 2'b10);
    check("c1_ready", ready, 0);
    check("c1_en", arr_en, 0);
    tick();
    check("c2_en", arr_en, 0);
    tick();
    check("c3_access", {arr_en, arr_rw, arr_bank, arr_addr, arr_wdata}, {1'b1, 1'b1, 1'b0, 3'h3, 8'hA5});
    tick();
    check("c4_done", {done, ready, rdata_valid}, 3'b110);
    req_r = 1'b1; addr = 4'h3;
    tick();
    req_r = 1'b0;
    check("c5_rd_access", {arr_en, arr_rw, done}, 3'b100);
    tick();
    check("c6_rdata", {rdata_valid, done, rdata}, {1'b1, 1'b1, 8'hA5});
    tick();
    check("c7_rdata_hold", {rdata_valid, rdata}, {1'b0, 8'hA5});
    tick();
    tick();
    check("c9_awake", bank_sleep, 2'b10);
    tick();
    check("c10_timeout", bank_sleep, 2'b11);

    // re-access bank 0 after it timed out: full wake delay again
    req_r = 1'b1; addr = 4'h3;
    tick();
    req_r = 1'b0;
    check("c11_wake", {bank_sleep, arr_en}, {2'b10, 1'b0});
    tick();
    tick();
    check("c13_access", arr_en, 1);
    tick();
    check("c14_rdata", {rdata_valid, rdata}, {1'b1, 8'hA5});

    // illegal request
    req_r = 1'b1; req_w = 1'b1;
    tick();
    req_r = 1'b0; req_w = 1'b0;
    check("c15_err", {err, ready, arr_en, bank_sleep}, {1'b1, 1'b1, 1'b0, 2'b10});
    tick();
    check("c16_err_clr", err, 0);

    // write to bank 1 with an ignored request while busy
    en_base = en_cnt;
    req_w = 1'b1; addr = 4'hB; wdata = 8'h3C;
    tick();
    addr = 4'h3; wdata = 8'hFF;
    check("c17_sleep", bank_sleep, 2'b00);
    tick();
    req_w = 1'b0;
    check("c18_b0_sleeps", bank_sleep, 2'b01);
    tick();
    check("c19_access", {arr_en, arr_rw, arr_bank, arr_addr, arr_wdata}, {1'b1, 1'b1, 1'b1, 3'h3, 8'h3C});
    tick();
    check("c20_done", {done, ready}, 2'b11);
    tick();
    check("c21_single_en", en_cnt - en_base, 1);
    check("c21_no_queue", arr_en, 0);
    req_r = 1'b1; addr = 4'hB;
    tick();
    req_r = 1'b0;
    check("c22_rd_b1", {arr_en, arr_bank}, 2'b11);
    tick();
    check("c23_rdata", {rdata_valid, rdata}, {1'b1, 8'h3C});
    tick();
    tick();
    tick();
    // bank 1 idle count is one short of timeout here; accept must win
    check("c26_b1_awake", bank_sleep[1], 0);
    req_r = 1'b1; addr = 4'hB;
    tick();
    req_r = 1'b0;
    check("c27_race_access", {arr_en, bank_sleep[1]}, 2'b10);
    tick();
    check("c28_rdata", {rdata_valid, rdata}, {1'b1, 8'h3C});

    // reset during WAKE
    req_w = 1'b1; addr = 4'h3; wdata = 8'h77;
    tick();
    req_w = 1'b0;
    check("c29_wake", {bank_sleep, ready}, {2'b00, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {bank_sleep, ready, arr_en, done}, {2'b11, 1'b1, 1'b0, 1'b0});
    en_base = en_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_no_en", en_cnt - en_base, 0);
    check("post_rst_state", {bank_sleep, ready}, {2'b11, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
